// File: rtl/dmem_gpio_pkg.sv
// Shared constants and address decode for the data-memory / GPIO bus.
package dmem_gpio_pkg;

  localparam int unsigned OFS_IN    = 0;
  localparam int unsigned OFS_OUT   = 1;
  localparam int unsigned OFS_EDGE  = 2;
  localparam int unsigned OFS_IEN   = 3;
  localparam int unsigned IO_STRIDE = 4;

  typedef struct packed {
    logic       hit;
    logic [3:0] ch;
    logic [1:0] ofs;
  } io_sel_t;

  // Map a word address onto (channel, register offset) inside the IO window.
  function automatic io_sel_t io_decode(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input int unsigned nch);
    io_sel_t     s;
    logic [31:0] rel;
    s   = '0;
    rel = a - base;
    if (a >= base && rel < IO_STRIDE * nch) begin
      s.hit = 1'b1;
      s.ch  = 4'(rel >> 2);
      s.ofs = 2'(rel);
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_gpio_bus_gpio_chan.sv
// One GPIO channel: input synchroniser, rising-edge flags with
// write-1-to-clear, output and interrupt-enable registers.
module gpio_chan #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pin,
  input  logic [DW-1:0] din,
  input  logic          we_out,
  input  logic          we_edge,
  input  logic          we_ien,
  output logic [DW-1:0] in_val,
  output logic [DW-1:0] out_val,
  output logic [DW-1:0] edge_val,
  output logic [DW-1:0] ien_val,
  output logic          irq_term
);

  logic [DW-1:0] s1, s2, s3;
  logic [DW-1:0] out_q, edge_q, ien_q;
  logic [DW-1:0] edge_set, edge_clr;

  assign edge_set = s2 & ~s3;
  assign edge_clr = we_edge ? din : '0;

  // two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // software-visible registers; a new edge beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      edge_q <= '0;
      ien_q  <= '0;
    end else begin
      if (we_out) out_q <= din;
      if (we_ien) ien_q <= din;
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  assign in_val   = s2;
  assign out_val  = out_q;
  assign edge_val = edge_q;
  assign ien_val  = ien_q;
  assign irq_term = |(edge_q & ien_q);

endmodule

// File: rtl/dmem_gpio_bus.sv
// Data memory with a memory-mapped window of GPIO channels on the core's
// data port. Single port, one-cycle synchronous read via registered address.
module dmem_gpio_bus
  import dmem_gpio_pkg::*;
#(
  parameter int            DP      = 1024,
  parameter int            DW      = 16,
  parameter int            AW      = 16,
  parameter int            NCH     = 2,
  parameter logic [AW-1:0] IO_BASE = 16'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  input  logic [NCH*DW-1:0] gpio_in,
  output logic [NCH*DW-1:0] gpio_out,
  output logic              irq
);

  localparam int MAW = (DP > 1) ? $clog2(DP) : 1;

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("dmem_gpio_bus: NCH must be in 1..16");
  end
  if (longint'(IO_BASE) + 4 * NCH > (longint'(1) << AW)) begin : g_bad_window
    $error("dmem_gpio_bus: IO window exceeds address space");
  end
  if (IO_BASE[1:0] != 2'b00) begin : g_bad_align
    $error("dmem_gpio_bus: IO_BASE must be 4-aligned");
  end

  logic [DW-1:0]  mem [DP];
  logic [AW-1:0]  addr_r;
  io_sel_t        wr_sel, rd_sel;
  logic           wr_mem_ok, rd_mem_ok;
  logic [NCH-1:0] we_out, we_edge, we_ien, irq_term;
  logic [DW-1:0]  in_val [NCH];
  logic [DW-1:0]  out_val [NCH];
  logic [DW-1:0]  edge_val [NCH];
  logic [DW-1:0]  ien_val [NCH];

  assign wr_sel    = io_decode(32'(addr), 32'(IO_BASE), NCH);
  assign rd_sel    = io_decode(32'(addr_r), 32'(IO_BASE), NCH);
  assign wr_mem_ok = 32'(addr) < DP;
  assign rd_mem_ok = 32'(addr_r) < DP;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign we_out[k]  = we && wr_sel.hit && wr_sel.ch == 4'(k) && wr_sel.ofs == 2'(OFS_OUT);
    assign we_edge[k] = we && wr_sel.hit && wr_sel.ch == 4'(k) && wr_sel.ofs == 2'(OFS_EDGE);
    assign we_ien[k]  = we && wr_sel.hit && wr_sel.ch == 4'(k) && wr_sel.ofs == 2'(OFS_IEN);

    gpio_chan #(.DW(DW)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .pin      (gpio_in[k*DW +: DW]),
      .din      (din),
      .we_out   (we_out[k]),
      .we_edge  (we_edge[k]),
      .we_ien   (we_ien[k]),
      .in_val   (in_val[k]),
      .out_val  (out_val[k]),
      .edge_val (edge_val[k]),
      .ien_val  (ien_val[k]),
      .irq_term (irq_term[k])
    );

    assign gpio_out[k*DW +: DW] = out_val[k];
  end

  // data store; rst gates the write so a reset landing on a write drops it,
  // and no reset on the array keeps it block-RAM friendly
  always_ff @(posedge clk) begin
    if (we && !rst && !wr_sel.hit && wr_mem_ok) mem[addr[MAW-1:0]] <= din;
  end

  // read address follows addr on non-write cycles only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      addr_r <= '0;
    else if (!we) addr_r <= addr;
  end

  // registered interrupt from all enabled edge flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_term;
  end

  // read mux: IO register, memory word, or zero when unmapped
  always_comb begin
    dout = '0;
    if (rd_sel.hit) begin
      for (int k = 0; k < NCH; k++) begin
        if (rd_sel.ch == 4'(k)) begin
          case (rd_sel.ofs)
            2'(OFS_IN):   dout = in_val[k];
            2'(OFS_OUT):  dout = out_val[k];
            2'(OFS_EDGE): dout = edge_val[k];
            2'(OFS_IEN):  dout = ien_val[k];
            default:      dout = '0;
          endcase
        end
      end
    end else if (rd_mem_ok) begin
      dout = mem[addr_r[MAW-1:0]];
    end
  end

endmodule

// File: tb/tb_dmem_gpio_bus.sv
// Self-checking bench for dmem_gpio_bus: directed steps followed by a random
// phase, all compared against a cycle-level behavioural model.
module tb_dmem_gpio_bus;

  localparam int            DP      = 1024;
  localparam int            DW      = 16;
  localparam int            AW      = 16;
  localparam int            NCH     = 2;
  localparam logic [AW-1:0] IO_BASE = 16'h100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic [DW-1:0]     din = '0;
  logic [DW-1:0]     dout;
  logic [NCH*DW-1:0] gpio_in = '0;
  logic [NCH*DW-1:0] gpio_out;
  logic              irq;

  dmem_gpio_bus #(.DP(DP), .DW(DW), .AW(AW), .NCH(NCH), .IO_BASE(IO_BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_out [NCH];
  logic [DW-1:0] m_edge [NCH];
  logic [DW-1:0] m_ien [NCH];
  logic [DW-1:0] m_pin [NCH][3];   // pin samples at the last three edges, [0] newest
  logic          m_irq;
  int            m_raddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int reg_addr(input int k, input int ofs);
    return int'(IO_BASE) + 4 * k + ofs;
  endfunction

  function automatic bit in_window(input int a);
    return a >= int'(IO_BASE) && a < int'(IO_BASE) + 4 * NCH;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_out[k]  = '0;
      m_edge[k] = '0;
      m_ien[k]  = '0;
      for (int j = 0; j < 3; j++) m_pin[k][j] = '0;
    end
    m_irq   = 1'b0;
    m_raddr = 0;
  endtask

  // one rising edge with the inputs currently on the bus
  task automatic model_clock();
    logic          irq_n;
    logic [DW-1:0] rise, clr;
    int            a;
    a     = int'(addr);
    irq_n = 1'b0;
    for (int k = 0; k < NCH; k++) irq_n = irq_n | (|(m_edge[k] & m_ien[k]));
    for (int k = 0; k < NCH; k++) begin
      rise = m_pin[k][1] & ~m_pin[k][2];
      clr  = (we && a == reg_addr(k, 2)) ? din : '0;
      m_edge[k] = (m_edge[k] & ~clr) | rise;
      if (we && a == reg_addr(k, 1)) m_out[k] = din;
      if (we && a == reg_addr(k, 3)) m_ien[k] = din;
      m_pin[k][2] = m_pin[k][1];
      m_pin[k][1] = m_pin[k][0];
      m_pin[k][0] = gpio_in[k*DW +: DW];
    end
    m_irq = irq_n;
    if (we && !in_window(a) && a < DP) m_mem[a] = din;
    if (!we) m_raddr = a;
  endtask

  function automatic bit exp_dout(output logic [DW-1:0] v);
    int k, o;
    v = '0;
    if (in_window(m_raddr)) begin
      k = (m_raddr - int'(IO_BASE)) / 4;
      o = (m_raddr - int'(IO_BASE)) % 4;
      case (o)
        0:       v = m_pin[k][1];
        1:       v = m_out[k];
        2:       v = m_edge[k];
        default: v = m_ien[k];
      endcase
      return 1'b1;
    end
    if (m_raddr < DP) begin
      if (!m_mem.exists(m_raddr)) return 1'b0;
      v = m_mem[m_raddr];
    end
    return 1'b1;
  endfunction

  task automatic chk_model();
    logic [NCH*DW-1:0] po;
    logic [DW-1:0]     v;
    for (int k = 0; k < NCH; k++) po[k*DW +: DW] = m_out[k];
    chk("model_gpio_out", 32'(gpio_out), 32'(po));
    chk("model_irq", 32'(irq), 32'(m_irq));
    if (exp_dout(v)) chk("model_dout", 32'(dout), 32'(v));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_clock();
    @(negedge clk);
    chk_model();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we   = 1'b1;
    addr = AW'(a);
    din  = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int a);
    addr = AW'(a);
    tick();
  endtask

  initial begin
    // backdoor preload so reads of these words are defined
    dut.mem[0]   = 16'h1111;
    dut.mem[257] = 16'h5A5A;
    m_mem[0]     = 16'h1111;
    m_mem[257]   = 16'h5A5A;
    model_reset();

    // reset state
    tick();
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_dout_mem0", 32'(dout), 32'h1111);
    #2 rst = 1'b0;

    // memory write/read, and dropped write beyond DP
    wr(5, 16'hBEEF);
    rd(5);
    chk("mem_rd5", 32'(dout), 32'hBEEF);
    wr(16'h400, 16'h1234);
    rd(16'h400);
    chk("mem_unmapped", 32'(dout), 32'h0);

    // window isolation
    wr(16'h101, 16'h1234);
    chk("out_ch0", 32'(gpio_out[15:0]), 32'h1234);
    rd(16'h101);
    chk("rd_out_ch0", 32'(dout), 32'h1234);
    chk("mem_shadow", 32'(dut.mem[257]), 32'h5A5A);

    // sync / edge / irq latency on ch1 bit3
    wr(16'h107, 16'h0008);
    addr = 16'h104;
    gpio_in[16+3] = 1'b1;
    tick();
    chk("in_bit3_n", 32'(dout[3]), 32'h0);
    tick();
    chk("in_bit3_n1", 32'(dout[3]), 32'h1);
    addr = 16'h106;
    tick();
    chk("edge_n2", 32'(dout), 32'h0008);
    chk("irq_n2", 32'(irq), 32'h0);
    tick();
    chk("irq_n3", 32'(irq), 32'h1);

    // write-1-to-clear
    wr(16'h106, 16'h0008);
    chk("w1c_clear", 32'(dout), 32'h0);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    tick();
    chk("w1c_irq_drop", 32'(irq), 32'h0);

    // clear colliding with a new edge: set wins
    gpio_in[16+3] = 1'b0;
    repeat (3) tick();
    gpio_in[16+3] = 1'b1;
    tick();
    tick();
    wr(16'h106, 16'h0008);
    chk("set_wins", 32'(dout), 32'h0008);

    // masking on ch0
    wr(16'h107, 16'h0000);
    wr(16'h106, 16'hFFFF);
    gpio_in[7:4] = 4'hF;
    repeat (3) tick();
    wr(16'h103, 16'h000F);
    tick();
    tick();
    chk("mask_irq0", 32'(irq), 32'h0);
    rd(16'h102);
    chk("mask_edge", 32'(dout), 32'h00F0);
    wr(16'h103, 16'h0010);
    chk("ien_irq_lag", 32'(irq), 32'h0);
    tick();
    chk("ien_irq", 32'(irq), 32'h1);

    // asynchronous reset mid-operation
    wr(16'h101, 16'hFFFF);
    chk("pre_rst_out", 32'(gpio_out[15:0]), 32'hFFFF);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    #2 rst = 1'b1;
    gpio_in[0] = 1'b1;
    #1;
    chk("async_rst_out", 32'(gpio_out), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    model_reset();
    tick();
    addr = 16'h102;
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_edge_n2", 32'(dout), 32'h0);
    tick();
    chk("rst_edge_n3", 32'(dout), 32'h00F1);

    // random phase
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      we  = ($urandom_range(0, 2) == 0);
      din = DW'($urandom);
      case (sel)
        0, 1, 2, 3: addr = AW'(int'(IO_BASE) + int'($urandom_range(0, 4 * NCH - 1)));
        4, 5:       addr = AW'($urandom_range(0, 15));
        6:          addr = AW'(DP + int'($urandom_range(0, 7)));
        default:    addr = AW'($urandom_range(0, DP - 1));
      endcase
      if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, NCH*DW - 1)] ^= 1'b1;
      tick();
    end
    we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
